// File: rtl/dirty_pkg.sv
// Shared types and helpers for the dirty-bit array: FSM state encoding and
// lowest-set-bit one-hot selection used by the write path.
package dirty_pkg;

    localparam int unsigned MAX_WAYS = 32;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        SCAN  = 3'd2,
        OFFER = 3'd3,
        DONE  = 3'd4
    } dirty_state_t;

    // Isolates the lowest set bit so a multi-hot way_hit still writes one way.
    function automatic logic [MAX_WAYS-1:0] lowest_onehot(input logic [MAX_WAYS-1:0] v);
        return v & (~v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/dirty_ff_array.sv
// WAYS x SETS flop storage: one masked read-modify-write port, one
// combinational read port, no reset (contents are cleared by the owner).
module dirty_ff_array #(
    parameter  int unsigned WAYS  = 4,
    parameter  int unsigned SETS  = 8192,
    localparam int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WAYS-1:0]  wmask,
    input  logic             wbit,
    input  logic [IDX_W-1:0] raddr,
    output logic [WAYS-1:0]  rdata_c
);

    logic [WAYS-1:0] mem [SETS];

    // Only the ways selected by wmask take wbit; the rest keep their value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wmask & {WAYS{wbit}});
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/dirty_array.sv
// Dirty-bit array with power-up clear sweep and a flush engine that offers
// each dirty set over a valid/ready handshake. Optional same-cycle write to
// read forwarding is enabled with DIRTY_BYPASS_EN.
module dirty_array
    import dirty_pkg::*;
#(
    parameter  int unsigned WAYS  = 4,
    parameter  int unsigned SETS  = 8192,
    localparam int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] ra,
    output logic [WAYS-1:0]  rd,
    input  logic             wr,
    input  logic [IDX_W-1:0] wa,
    input  logic [WAYS-1:0]  way_hit,
    input  logic             in,
    input  logic             flush_req,
    output logic             busy,
    output logic             flush_valid,
    input  logic             flush_ready,
    output logic [IDX_W-1:0] flush_idx,
    output logic [WAYS-1:0]  flush_mask,
    output logic             flush_done
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(SETS - 1);

    dirty_state_t     state, state_d;
    logic [IDX_W-1:0] cursor, cursor_d;
    logic             we_c;
    logic             wbit_c;
    logic [IDX_W-1:0] waddr_c;
    logic [IDX_W-1:0] raddr_c;
    logic [WAYS-1:0]  wmask_c;
    logic [WAYS-1:0]  hit_onehot_c;
    logic [WAYS-1:0]  rdata_c;
    logic [WAYS-1:0]  rd_d;

    assign hit_onehot_c = WAYS'(lowest_onehot(MAX_WAYS'(way_hit)));

    // The single read port serves the flush cursor while a flush walks the array.
    assign raddr_c = (state == SCAN || state == OFFER) ? cursor : ra;

    dirty_ff_array #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_store (
        .clk     (clk),
        .we      (we_c),
        .waddr   (waddr_c),
        .wmask   (wmask_c),
        .wbit    (wbit_c),
        .raddr   (raddr_c),
        .rdata_c (rdata_c)
    );

    // Next state, cursor and write-port steering.
    always_comb begin
        state_d  = state;
        cursor_d = cursor;
        we_c     = 1'b0;
        waddr_c  = cursor;
        wmask_c  = '1;
        wbit_c   = 1'b0;
        case (state)
            INIT: begin
                we_c = 1'b1;
                if (cursor == LAST) begin
                    state_d  = IDLE;
                    cursor_d = '0;
                end else begin
                    cursor_d = cursor + IDX_W'(1);
                end
            end
            IDLE: begin
                we_c    = wr && (|way_hit);
                waddr_c = wa;
                wmask_c = hit_onehot_c;
                wbit_c  = in;
                if (flush_req) begin
                    state_d  = SCAN;
                    cursor_d = '0;
                end
            end
            SCAN: begin
                if (|rdata_c) begin
                    state_d = OFFER;
                end else if (cursor == LAST) begin
                    state_d = DONE;
                end else begin
                    cursor_d = cursor + IDX_W'(1);
                end
            end
            OFFER: begin
                if (flush_ready) begin
                    we_c = 1'b1;
                    if (cursor == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SCAN;
                        cursor_d = cursor + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = INIT;
                cursor_d = '0;
            end
        endcase
    end

    // Read data; zero whenever the port is not serving ra.
    always_comb begin
        rd_d = '0;
        if (state == IDLE || state == DONE) begin
            rd_d = rdata_c;
`ifdef DIRTY_BYPASS_EN
            if (we_c && (waddr_c == raddr_c)) begin
                rd_d = (rdata_c & ~wmask_c) | (wmask_c & {WAYS{wbit_c}});
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            cursor      <= '0;
            rd          <= '0;
            busy        <= 1'b1;
            flush_valid <= 1'b0;
            flush_done  <= 1'b0;
            flush_idx   <= '0;
            flush_mask  <= '0;
        end else begin
            state       <= state_d;
            cursor      <= cursor_d;
            rd          <= rd_d;
            busy        <= (state_d != IDLE);
            flush_valid <= (state_d == OFFER);
            flush_done  <= (state_d == DONE);
            // Offer payload is captured on entry and held until accepted.
            if (state == SCAN && state_d == OFFER) begin
                flush_idx  <= cursor;
                flush_mask <= rdata_c;
            end else if (state_d != OFFER) begin
                flush_idx  <= '0;
                flush_mask <= '0;
            end
        end
    end

endmodule
